// File: rtl/ctrl_pipe_chain_if.sv
// Control-bundle pipeline bus: decode-side inputs, stall/flush requests and per-stage outputs.
// The master modport drives the requests; the slave modport is the pipeline itself.
interface ctrl_pipe_chain_if #(
  parameter int WIDTH  = 20,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
);
  logic [WIDTH-1:0]        ctrl_d;
  logic                    valid_d;
  logic [STAGES-1:0]       stall;
  logic [STAGES-1:0]       flush;
  logic                    excflush;
  logic                    cnt_clr;
  logic [STAGES*WIDTH-1:0] ctrl_q;
  logic [STAGES-1:0]       valid_q;
  logic [STAGES-1:0]       stall_eff;
  logic [CNT_W-1:0]        bubble_cnt;

  modport master (
    output ctrl_d, valid_d, stall, flush, excflush, cnt_clr,
    input  ctrl_q, valid_q, stall_eff, bubble_cnt
  );

  modport slave (
    input  ctrl_d, valid_d, stall, flush, excflush, cnt_clr,
    output ctrl_q, valid_q, stall_eff, bubble_cnt
  );
endinterface

// File: rtl/ctrl_pipe_chain.sv
// Parametrised control-bundle pipeline (E/M/W...) with per-stage valid, stall, flush,
// backward stall propagation, bubble insertion and a saturating bubble counter.
module ctrl_pipe_chain #(
  parameter int WIDTH      = 20,
  parameter int STAGES     = 3,
  parameter int AUTO_STALL = 1,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  ctrl_pipe_chain_if.slave bus
);

  logic [STAGES-1:0][WIDTH-1:0] ctrlQ;
  logic [STAGES-1:0]            validQ;
  logic [STAGES-1:0]            stallEff;
  logic [STAGES-1:0]            clrStage;
  logic [STAGES-1:0]            bubbleStage;
  logic [CNT_W-1:0]             bubbleCnt;
  logic                         bubbleAny;

  // Stall propagates from the oldest stage back towards decode.
  always_comb begin
    stallEff = '0;
    stallEff[STAGES-1] = bus.stall[STAGES-1];
    for (int unsigned i = 1; i < STAGES; i++) begin
      stallEff[STAGES-1-i] = bus.stall[STAGES-1-i] |
                             ((AUTO_STALL != 0) & stallEff[STAGES-i]);
    end
  end

  // A bubble enters stage k when it is free to advance but its feeder is held.
  always_comb begin
    clrStage    = {STAGES{bus.excflush}} | bus.flush;
    bubbleStage = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      bubbleStage[k] = ~clrStage[k] & ~stallEff[k] & stallEff[k-1];
    end
  end

  assign bubbleAny = |bubbleStage;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrlQ  <= '0;
      validQ <= '0;
    end else begin
      if (clrStage[0]) begin
        ctrlQ[0]  <= '0;
        validQ[0] <= 1'b0;
      end else if (!stallEff[0]) begin
        ctrlQ[0]  <= bus.valid_d ? bus.ctrl_d : '0;
        validQ[0] <= bus.valid_d;
      end

      for (int unsigned k = 1; k < STAGES; k++) begin
        if (clrStage[k]) begin
          ctrlQ[k]  <= '0;
          validQ[k] <= 1'b0;
        end else if (!stallEff[k]) begin
          if (stallEff[k-1]) begin
            ctrlQ[k]  <= '0;
            validQ[k] <= 1'b0;
          end else begin
            ctrlQ[k]  <= ctrlQ[k-1];
            validQ[k] <= validQ[k-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bubbleCnt <= '0;
    end else if (bus.cnt_clr) begin
      bubbleCnt <= '0;
    end else if (bubbleAny && (bubbleCnt != '1)) begin
      bubbleCnt <= bubbleCnt + 1'b1;
    end
  end

  assign bus.ctrl_q     = ctrlQ;
  assign bus.valid_q    = validQ;
  assign bus.stall_eff  = stallEff;
  assign bus.bubble_cnt = bubbleCnt;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed table-driven bench for ctrl_pipe_chain (WIDTH=8, STAGES=3, AUTO_STALL=1),
// with a second CNT_W=2 instance sharing the stimulus to exercise counter saturation.
module tb_ctrl_pipe_chain;

  logic clk;
  logic rst;
  int unsigned nCmp;
  int unsigned nFail;

  ctrl_pipe_chain_if #(.WIDTH(8), .STAGES(3), .CNT_W(16)) busA ();
  ctrl_pipe_chain_if #(.WIDTH(8), .STAGES(3), .CNT_W(2))  busB ();

  assign busB.ctrl_d   = busA.ctrl_d;
  assign busB.valid_d  = busA.valid_d;
  assign busB.stall    = busA.stall;
  assign busB.flush    = busA.flush;
  assign busB.excflush = busA.excflush;
  assign busB.cnt_clr  = busA.cnt_clr;

  ctrl_pipe_chain #(.WIDTH(8), .STAGES(3), .AUTO_STALL(1), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busA.slave)
  );

  ctrl_pipe_chain #(.WIDTH(8), .STAGES(3), .AUTO_STALL(1), .CNT_W(2)) dutSat (
    .clk (clk),
    .rst (rst),
    .bus (busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ctrl;
    logic        vd;
    logic [2:0]  st;
    logic [2:0]  fl;
    logic        ex;
    logic        clr;
    logic [2:0]  expSe;
    logic [23:0] expQ;
    logic [2:0]  expV;
    int unsigned expCnt;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic [7:0] ctrl, logic vd, logic [2:0] st, logic [2:0] fl,
                              logic ex, logic clr, logic [2:0] expSe, logic [23:0] expQ,
                              logic [2:0] expV, int unsigned expCnt);
    vec_t v;
    v.ctrl = ctrl; v.vd = vd; v.st = st; v.fl = fl; v.ex = ex; v.clr = clr;
    v.expSe = expSe; v.expQ = expQ; v.expV = expV; v.expCnt = expCnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] ctrl, input logic vd, input logic [2:0] st,
                       input logic [2:0] fl, input logic ex, input logic clr);
    busA.ctrl_d   = ctrl;
    busA.valid_d  = vd;
    busA.stall    = st;
    busA.flush    = fl;
    busA.excflush = ex;
    busA.cnt_clr  = clr;
  endtask

  initial begin
    nCmp  = 0;
    nFail = 0;

    //            ctrl   vd  stall   flush   ex    clr   stallEff  ctrl_q {s2,s1,s0}  valid   cnt
    tbl[0]  = mk(8'h11, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 24'hA5A511, 3'b111, 0);
    tbl[1]  = mk(8'h22, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 24'hA51122, 3'b111, 0);
    tbl[2]  = mk(8'h33, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 24'h112233, 3'b111, 0);
    tbl[3]  = mk(8'h44, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0, 3'b011, 24'h002233, 3'b011, 1);
    tbl[4]  = mk(8'h44, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0, 3'b011, 24'h002233, 3'b011, 2);
    tbl[5]  = mk(8'h44, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 24'h223344, 3'b111, 2);
    tbl[6]  = mk(8'h55, 1'b1, 3'b001, 3'b001, 1'b0, 1'b0, 3'b001, 24'h330000, 3'b100, 3);
    tbl[7]  = mk(8'h66, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 24'h000066, 3'b001, 3);
    tbl[8]  = mk(8'h77, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 24'h006677, 3'b011, 3);
    tbl[9]  = mk(8'h88, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 24'h667788, 3'b111, 3);
    tbl[10] = mk(8'h99, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 24'h000000, 3'b000, 3);
    tbl[11] = mk(8'hAA, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b000, 3);
    tbl[12] = mk(8'hBB, 1'b1, 3'b100, 3'b000, 1'b0, 1'b0, 3'b111, 24'h000000, 3'b000, 3);
    tbl[13] = mk(8'hBB, 1'b1, 3'b000, 3'b010, 1'b0, 1'b0, 3'b000, 24'h0000BB, 3'b001, 3);
    tbl[14] = mk(8'hCC, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 24'h00BBCC, 3'b011, 3);
    tbl[15] = mk(8'hDD, 1'b1, 3'b100, 3'b000, 1'b0, 1'b0, 3'b111, 24'h00BBCC, 3'b011, 3);
    tbl[16] = mk(8'hDD, 1'b1, 3'b100, 3'b001, 1'b0, 1'b0, 3'b111, 24'h00BB00, 3'b010, 3);
    tbl[17] = mk(8'hDD, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 24'hBB00DD, 3'b101, 0);

    // Reset held for two edges with a live instruction and a stall on the inputs.
    rst = 1'b0;
    drive(8'hA5, 1'b1, 3'b100, 3'b000, 1'b0, 1'b0);
    #1;
    check("rst_stall_eff", 32'(busA.stall_eff), 32'h7);
    tick();
    tick();
    check("rst_ctrl_q", 32'(busA.ctrl_q), 32'h0);
    check("rst_valid_q", 32'(busA.valid_q), 32'h0);
    check("rst_cnt", 32'(busA.bubble_cnt), 32'h0);
    check("rst_cnt_sat", 32'(busB.bubble_cnt), 32'h0);

    busA.stall = 3'b000;
    rst = 1'b1;
    tick();
    check("rel_e1_valid", 32'(busA.valid_q), 32'h1);
    tick();
    check("rel_e2_valid", 32'(busA.valid_q), 32'h3);
    check("rel_e2_ctrl", 32'(busA.ctrl_q), 32'h00A5A5);
    tick();
    check("rel_e3_ctrl", 32'(busA.ctrl_q), 32'hA5A5A5);
    check("rel_e3_valid", 32'(busA.valid_q), 32'h7);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].ctrl, tbl[i].vd, tbl[i].st, tbl[i].fl, tbl[i].ex, tbl[i].clr);
      #1;
      check($sformatf("v%0d_stall_eff", i), 32'(busA.stall_eff), 32'(tbl[i].expSe));
      tick();
      check($sformatf("v%0d_ctrl_q", i), 32'(busA.ctrl_q), 32'(tbl[i].expQ));
      check($sformatf("v%0d_valid_q", i), 32'(busA.valid_q), 32'(tbl[i].expV));
      check($sformatf("v%0d_cnt", i), 32'(busA.bubble_cnt), tbl[i].expCnt);
      check($sformatf("v%0d_cnt_sat", i), 32'(busB.bubble_cnt),
            (tbl[i].expCnt > 3) ? 32'd3 : tbl[i].expCnt);
    end

    // Five bubble edges: the 2-bit counter saturates, the 16-bit one keeps counting.
    drive(8'hEE, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat%0d_v2", i), 32'(busA.valid_q[2]), 32'h0);
    end
    check("sat_cnt16", 32'(busA.bubble_cnt), 32'd5);
    check("sat_cnt2", 32'(busB.bubble_cnt), 32'd3);

    // Clear wins over a same-cycle bubble; counting resumes afterwards.
    busA.cnt_clr = 1'b1;
    tick();
    check("clr_cnt16", 32'(busA.bubble_cnt), 32'd0);
    check("clr_cnt2", 32'(busB.bubble_cnt), 32'd0);
    busA.cnt_clr = 1'b0;
    tick();
    check("resume_cnt16", 32'(busA.bubble_cnt), 32'd1);
    check("resume_cnt2", 32'(busB.bubble_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
